pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the forwarding-enabled ARM pipeline with external SRAM. It decides when the front end must hold for a load-use hazard that forwarding cannot cover. It also freezes the whole pipeline while a multi-cycle SRAM access completes, and gates branch flushes against those freezes. Two saturating counters record hazard and memory-wait cycles. It sits beside the forwarding unit, consumes the same stage destination/write-back information, and drives the pipeline-register enables and the SRAM strobes.

---
 rtl/arm_pipe_pkg.sv | 23 ++
 rtl/sram_wait_fsm.sv | 89 ++++++++
 rtl/pipeline_stall_controller.sv | 83 ++++++++
 tb/tb_pipeline_stall_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline stall/flush control slice.
package arm_pipe_pkg;

   localparam int SRAM_WAIT_DEF = 5;
   localparam int REG_W         = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } sram_state_e;

   // True when the ID instruction reads register dest through either operand.
   function automatic logic reg_match(
      input logic [REG_W-1:0] src1,
      input logic [REG_W-1:0] src2,
      input logic             two_src,
      input logic [REG_W-1:0] dest
   );
      return (src1 == dest) | (two_src & (src2 == dest));
   endfunction

endpackage

// File: rtl/sram_wait_fsm.sv
// Multi-cycle SRAM access sequencer: holds the pipeline for SRAM_WAIT access
// cycles, drives the write strobe and captures read data.
module sram_wait_fsm
   import arm_pipe_pkg::*;
#(
   parameter int SRAM_WAIT = SRAM_WAIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] sram_dq_in,
   output logic        freeze,
   output logic        sram_we_n,
   output logic        mem_ready,
   output logic [31:0] mem_rdata
);

   localparam int                WCNT_W    = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(SRAM_WAIT - 1);

   sram_state_e       r_state;
   sram_state_e       w_next_state;
   logic [WCNT_W-1:0] r_wcnt;
   logic              r_is_write;
   logic [31:0]       r_rdata;
   logic              w_req;

   assign w_req     = mem_r_en | mem_w_en;
   assign mem_rdata = r_rdata;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned
      // and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_req) w_next_state = ACCESS;
         ACCESS:  if (r_wcnt == '0) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // A simultaneous read and write request is latched as a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wcnt     <= '0;
         r_is_write <= 1'b0;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_wcnt     <= WCNT_LOAD;
                  r_is_write <= mem_w_en;
               end
            end
            ACCESS: begin
               if (r_wcnt != '0)     r_wcnt  <= r_wcnt - 1'b1;
               else if (!r_is_write) r_rdata <= sram_dq_in;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      freeze    = 1'b0;
      sram_we_n = 1'b1;
      mem_ready = 1'b0;
      case (r_state)
         IDLE:    freeze = w_req;
         ACCESS: begin
            freeze    = 1'b1;
            sram_we_n = ~r_is_write;
         end
         DONE:    mem_ready = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Load-use hazard detection, branch flush gating against SRAM freezes, and
// saturating hazard/memory-wait cycle counters.
module pipeline_stall_controller
   import arm_pipe_pkg::*;
#(
   parameter int SRAM_WAIT = SRAM_WAIT_DEF,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fwd_en,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_r_en,
   input  logic             mem_w_en,
   input  logic             branch_taken,
   input  logic [31:0]      sram_dq_in,
   output logic             hazard_stall,
   output logic             freeze,
   output logic             flush,
   output logic             sram_we_n,
   output logic             mem_ready,
   output logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] hazard_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             w_match_exe;
   logic             w_match_mem;
   logic             w_raw_hazard;
   logic [CNT_W-1:0] r_hazard_cnt;
   logic [CNT_W-1:0] r_wait_cnt;

   sram_wait_fsm #(
      .SRAM_WAIT (SRAM_WAIT)
   ) u_sram_wait_fsm (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .sram_dq_in (sram_dq_in),
      .freeze     (freeze),
      .sram_we_n  (sram_we_n),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   assign w_match_exe = reg_match(id_src1, id_src2, id_two_src, exe_dest);
   assign w_match_mem = reg_match(id_src1, id_src2, id_two_src, mem_dest);

   // With forwarding only an EXE load is uncoverable; without it any pending write is.
   assign w_raw_hazard = fwd_en
      ? (id_valid & exe_wb_en & exe_mem_r_en & w_match_exe)
      : (id_valid & ((exe_wb_en & w_match_exe) | (mem_wb_en & w_match_mem)));

   assign flush        = branch_taken & ~freeze;
   assign hazard_stall = w_raw_hazard & ~flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hazard_cnt <= '0;
         r_wait_cnt   <= '0;
      end else begin
         if (hazard_stall && !freeze && r_hazard_cnt != CNT_MAX)
            r_hazard_cnt <= r_hazard_cnt + 1'b1;
         if (freeze && r_wait_cnt != CNT_MAX)
            r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign hazard_cnt = r_hazard_cnt;
   assign wait_cnt   = r_wait_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: timeline reference model,
// directed scenarios, then randomized traffic.
module tb_pipeline_stall_controller;
   import arm_pipe_pkg::*;

   localparam int SW   = 5;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          fwd_en, id_valid, id_two_src;
   logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
   logic          exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic          mem_r_en, mem_w_en, branch_taken;
   logic [31:0]   sram_dq_in;
   logic          hazard_stall, freeze, flush, sram_we_n, mem_ready;
   logic [31:0]   mem_rdata;
   logic [CW-1:0] hazard_cnt, wait_cnt;

   pipeline_stall_controller #(
      .SRAM_WAIT (SW),
      .CNT_W     (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fwd_en       (fwd_en),
      .id_valid     (id_valid),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .mem_r_en     (mem_r_en),
      .mem_w_en     (mem_w_en),
      .branch_taken (branch_taken),
      .sram_dq_in   (sram_dq_in),
      .hazard_stall (hazard_stall),
      .freeze       (freeze),
      .flush        (flush),
      .sram_we_n    (sram_we_n),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .hazard_cnt   (hazard_cnt),
      .wait_cnt     (wait_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: an access is a time window [start, start+SW+1] rather than states.
   int          cyc;
   int          m_start;
   int          m_hcnt;
   int          m_wcnt;
   bit          m_busy;
   bit          m_wr;
   logic [31:0] m_rdata;
   logic [31:0] exp_q[$];
   int          we_low;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_hazard();
      bit reads_exe, reads_mem;
      reads_exe = (id_src1 == exe_dest) || (id_two_src && id_src2 == exe_dest);
      reads_mem = (id_src1 == mem_dest) || (id_two_src && id_src2 == mem_dest);
      if (!id_valid) return 1'b0;
      if (fwd_en)    return exe_wb_en && exe_mem_r_en && reads_exe;
      return (exe_wb_en && reads_exe) || (mem_wb_en && reads_mem);
   endfunction

   task automatic clear_inputs();
      fwd_en = 1'b1; id_valid = 1'b0; id_two_src = 1'b0;
      id_src1 = '0; id_src2 = '0; exe_dest = '0; mem_dest = '0;
      exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
      mem_r_en = 1'b0; mem_w_en = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic model_reset();
      cyc = 0; m_start = 0; m_hcnt = 0; m_wcnt = 0;
      m_busy = 1'b0; m_wr = 1'b0; m_rdata = '0;
      exp_q.delete();
   endtask

   // Called just after a falling edge with inputs driven; checks this cycle and advances the model.
   task automatic step();
      bit req, in_acc, done, fz, fl, hs;
      #1;
      req    = mem_r_en || mem_w_en;
      in_acc = m_busy && cyc > m_start && cyc <= m_start + SW;
      done   = m_busy && cyc == m_start + SW + 1;
      fz     = (!m_busy && req) || in_acc;
      fl     = branch_taken && !fz;
      hs     = model_hazard() && !fl;
      check("freeze",       freeze,       fz);
      check("flush",        flush,        fl);
      check("hazard_stall", hazard_stall, hs);
      check("sram_we_n",    sram_we_n,    !(in_acc && m_wr));
      check("mem_ready",    mem_ready,    done);
      check("hazard_cnt",   hazard_cnt,   m_hcnt);
      check("wait_cnt",     wait_cnt,     m_wcnt);
      if (sram_we_n === 1'b0) we_low++;
      if (hs && !fz && m_hcnt < CMAX) m_hcnt++;
      if (fz && m_wcnt < CMAX)        m_wcnt++;
      if (m_busy && cyc == m_start + SW) begin
         if (!m_wr) m_rdata = sram_dq_in;
         exp_q.push_back(m_rdata);
      end
      if (done) m_busy = 1'b0;
      else if (!m_busy && req) begin
         m_busy  = 1'b1;
         m_start = cyc;
         m_wr    = mem_w_en;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   // Monitor: every completed access must present the scoreboard's next read-data value.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1 && mem_ready === 1'b1) begin
            if (exp_q.size() == 0) check("mem_ready_unexpected", mem_ready, 1'b0);
            else begin
               e = exp_q.pop_front();
               check("mem_rdata", mem_rdata, e);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      sram_dq_in = '0;
      we_low     = 0;
      model_reset();
      #2;
      check("rst_mem_ready",  mem_ready,  1'b0);
      check("rst_sram_we_n",  sram_we_n,  1'b1);
      check("rst_mem_rdata",  mem_rdata,  32'h0);
      check("rst_hazard_cnt", hazard_cnt, 0);
      check("rst_wait_cnt",   wait_cnt,   0);
      check("rst_freeze",     freeze,     1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // Load-use hazard with forwarding.
      exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd3; id_valid = 1'b1; id_src1 = 4'd3;
      step();
      clear_inputs();
      step();
      check("loaduse_hazard_cnt", hazard_cnt, 1);

      // ALU producer: covered by forwarding, stalls without it.
      exe_wb_en = 1'b1; exe_dest = 4'd3; id_valid = 1'b1; id_src1 = 4'd3;
      step();
      fwd_en = 1'b0;
      step();
      clear_inputs();
      step();

      // SRAM read.
      pulse_reset();
      mem_r_en = 1'b1; sram_dq_in = 32'hDEADBEEF;
      step();
      mem_r_en = 1'b0;
      repeat (SW + 1) step();
      check("read_wait_cnt",  wait_cnt,  6);
      check("read_mem_rdata", mem_rdata, 32'hDEADBEEF);
      step();

      // SRAM write with a branch held across it.
      we_low = 0;
      mem_w_en = 1'b1; branch_taken = 1'b1; sram_dq_in = $urandom;
      step();
      mem_w_en = 1'b0;
      repeat (SW + 1) step();
      branch_taken = 1'b0;
      step();
      check("write_we_n_low_cycles", we_low, SW);

      // Reset in the middle of an access.
      mem_w_en = 1'b1;
      step();
      mem_w_en = 1'b0;
      step();
      rst = 1'b0;
      #1;
      check("midrst_sram_we_n",  sram_we_n,  1'b1);
      check("midrst_mem_ready",  mem_ready,  1'b0);
      check("midrst_freeze",     freeze,     1'b0);
      check("midrst_hazard_cnt", hazard_cnt, 0);
      check("midrst_wait_cnt",   wait_cnt,   0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (SW + 3) step();

      // Counter saturation.
      exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd5;
      id_valid = 1'b1; id_two_src = 1'b1; id_src1 = 4'd0; id_src2 = 4'd5;
      repeat (20) step();
      clear_inputs();
      step();
      check("sat_hazard_cnt", hazard_cnt, 15);

      // Randomized traffic.
      pulse_reset();
      repeat (2000) begin
         if ($urandom_range(0, 15) == 0) fwd_en = ~fwd_en;
         id_valid     = ($urandom_range(0, 3) != 0);
         id_two_src   = $urandom_range(0, 1) == 1;
         id_src1      = 4'($urandom_range(0, 3));
         id_src2      = 4'($urandom_range(0, 3));
         exe_dest     = 4'($urandom_range(0, 3));
         mem_dest     = 4'($urandom_range(0, 3));
         exe_wb_en    = $urandom_range(0, 1) == 1;
         exe_mem_r_en = $urandom_range(0, 2) == 0;
         mem_wb_en    = $urandom_range(0, 1) == 1;
         mem_r_en     = $urandom_range(0, 5) == 0;
         mem_w_en     = $urandom_range(0, 5) == 0;
         branch_taken = $urandom_range(0, 5) == 0;
         sram_dq_in   = $urandom;
         step();
      end
      clear_inputs();
      repeat (SW + 3) step();
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
